// File: rtl/divider.sv
// Sequential radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
// Operands and results move through valid/ready handshakes; one operation in flight.
module divider #(
  parameter int unsigned WIDTH_N = 16,
  parameter int unsigned WIDTH_D = 16
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH_N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH_N-1:0] dvd_q, dvd_d;   // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH_D-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH_D-1:0] dsr_q, dsr_d;   // divisor magnitude
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               dbz_q, dbz_d;

  logic               in_ready_d;
  logic               out_valid_d;
  logic [WIDTH_N-1:0] quotient_d;
  logic [WIDTH_D-1:0] remainder_d;
  logic               div_by_zero_d;

  logic               a_neg, b_neg;
  logic [WIDTH_N-1:0] a_mag;
  logic [WIDTH_D-1:0] b_mag;
  logic [WIDTH_D:0]   rem_shift;
  logic [WIDTH_D-1:0] trial;
  logic               ge;

  // Operand sign detection and magnitudes at the input port
  always_comb begin
    a_neg = is_signed & dividend[WIDTH_N-1];
    b_neg = is_signed & divisor[WIDTH_D-1];
    a_mag = a_neg ? (~dividend + WIDTH_N'(1)) : dividend;
    b_mag = b_neg ? (~divisor + WIDTH_D'(1)) : divisor;
  end

  // One restoring step; an unsigned compare keeps a zero divisor on the all-ones path
  always_comb begin
    rem_shift = {rem_q, dvd_q[WIDTH_N-1]};
    ge        = (rem_shift >= {1'b0, dsr_q});
    trial     = rem_shift[WIDTH_D-1:0] - dsr_q;
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    dvd_d         = dvd_q;
    rem_d         = rem_q;
    dsr_d         = dsr_q;
    cnt_d         = cnt_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    dbz_d         = dbz_q;
    in_ready_d    = in_ready;
    out_valid_d   = out_valid;
    quotient_d    = quotient;
    remainder_d   = remainder;
    div_by_zero_d = div_by_zero;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          dvd_d      = a_mag;
          dsr_d      = b_mag;
          rem_d      = '0;
          q_neg_d    = a_neg ^ b_neg;
          r_neg_d    = a_neg;
          dbz_d      = (divisor == '0);
          cnt_d      = CW'(WIDTH_N);
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        rem_d = ge ? trial : rem_shift[WIDTH_D-1:0];
        dvd_d = {dvd_q[WIDTH_N-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dbz_q) begin
          quotient_d = '1;
        end else if (q_neg_q) begin
          quotient_d = ~dvd_q + WIDTH_N'(1);
        end else begin
          quotient_d = dvd_q;
        end
        remainder_d   = r_neg_q ? (~rem_q + WIDTH_D'(1)) : rem_q;
        div_by_zero_d = dbz_q;
        out_valid_d   = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dbz_q       <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dbz_q       <= dbz_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= div_by_zero_d;
    end
  end

endmodule

// File: doc/divider.md
# divider

Sequential signed/unsigned integer divider, the inverse operator of the team's `multiplier` block, for datapaths that need `a / b` and `a % b` without a large combinational array. It uses a radix-2 restoring algorithm, one quotient bit per cycle, and handles one operation at a time. Operands enter and results leave through valid/ready handshakes so the block can sit between pipeline stages that apply backpressure.

## Interface

Parameters:
- `WIDTH_N`, 16: dividend and quotient width (>= 2).
- `WIDTH_D`, 16: divisor and remainder width (>= 2).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `srst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; sampled on accept.
- `dividend`  in  `WIDTH_N`  numerator.
- `divisor`  in  `WIDTH_D`  denominator.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `quotient`  out  `WIDTH_N`  result quotient.
- `remainder`  out  `WIDTH_D`  result remainder.
- `div_by_zero`  out  1  the held result came from a zero divisor.

## Operation

- FSM states: IDLE, CALC, FIX, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid && in_ready`, register `is_signed` and the operand magnitudes. In signed mode, negate a negative operand.
  - Record the quotient sign (operand signs differ) and the remainder sign (the dividend's sign).
  - Load the iteration counter with `WIDTH_N` and go to CALC.
- CALC
  - Each cycle: shift the partial remainder (`WIDTH_D`+1 bits) left, bringing in the dividend MSB.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter; after exactly `WIDTH_N` iterations go to FIX.
- FIX
  - Apply the recorded signs by two's-complement negation.
  - Load the output registers, set `out_valid`, and go to DONE.
- DONE
  - Outputs held stable while `out_valid && !out_ready`.
  - On `out_valid && out_ready`, clear `out_valid` and go to IDLE.
- Arithmetic rules
  - Quotient truncates toward zero.
  - The remainder takes the dividend's sign and satisfies `dividend = quotient*divisor + remainder`, with results truncated to the port widths.
- Divide by zero
  - No special path; same latency.
  - Result: `quotient` = all ones, `remainder` = dividend truncated/sign-wrapped to `WIDTH_D`, `div_by_zero`=1.
  - `div_by_zero`=0 for every other result.
- Signed overflow (most-negative dividend / -1)
  - `quotient` = dividend (wraps), `remainder` = 0. This falls out of the restoring datapath; no extra logic.
- Unsigned mode applies no sign correction; operands are pure magnitudes.
- `in_ready` is 0 in CALC, FIX and DONE. A new operation is never accepted while a result is pending.

## Timing

- Reset
  - `srst` returns the FSM to IDLE from any state on the next edge and aborts any in-flight operation; no result is produced.
  - Reset values: `in_ready`=1, `out_valid`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
- Latency
  - Accept edge = cycle 0; CALC covers cycles 1..`WIDTH_N`; FIX is cycle `WIDTH_N`+1.
  - `out_valid` is high from cycle `WIDTH_N`+2 (18 for the defaults).
- Throughput
  - With `out_ready` tied high, `in_ready` returns one cycle after the result transfer.
  - Minimum issue interval: `WIDTH_N`+3 cycles.
- `in_valid` while `in_ready`=0 is ignored; the source must hold it.
- Operands may change freely after the accept edge.
- `out_ready` is sampled only in DONE.

## Test plan

- Unsigned 100 / 7, `WIDTH_N`=`WIDTH_D`=16 -> `quotient`=14, `remainder`=2, `div_by_zero`=0; `out_valid` rises exactly 18 cycles after accept.
- Signed -100 (0xFF9C) / 7 -> `quotient`=0xFFF2, `remainder`=0xFFFE. Signed 100 / -7 -> `quotient`=0xFFF2, `remainder`=0x0002.
- 0x8000 / 0xFFFF signed -> `quotient`=0x8000, `remainder`=0. Same operands unsigned -> `quotient`=0, `remainder`=0x8000.
- 1234 / 0, both modes -> `quotient`=0xFFFF, `remainder`=0x04D2, `div_by_zero`=1, same 18-cycle latency.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE -> outputs stable, `in_ready`=0 and a second `in_valid` is ignored. Release -> one transfer, `in_ready`=1 on the next cycle, second operation accepted.
- Assert `srst` one cycle at CALC cycle 5 -> next cycle `in_ready`=1, `out_valid`=0, outputs 0. A following 9 / 3 unsigned returns `quotient`=3, `remainder`=0.
- Random sweep against a reference model, both modes, including zero and extreme operands.
